csr_enc_hls_deadlock_report: RTL

Consumer of the csr_enc deadlock monitor output: qualifies the monitor's per-cycle `block` indication into a sticky, debounced deadlock event. On entry it captures a snapshot of the AXIS-block and instance-idle vectors, raises a one-cycle interrupt, and keeps saturating stall and event statistics until software clears it. Sits beside the csr_enc HLS instance, fed by the top-level deadlock monitor, with outputs routed to the debug register file.

---
 rtl/csr_enc_deadlock_pkg.sv | 19 +
 rtl/csr_enc_sat_counter.sv | 38 +++
 rtl/csr_enc_hls_deadlock_report.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/csr_enc_deadlock_pkg.sv
// Shared types and constants for the csr_enc deadlock report block.
// Holds the FSM state encoding, the statistic widths and the threshold helper.
package csr_enc_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  localparam int STALL_W = 32;
  localparam int EVT_W   = 8;

  // A programmed threshold of zero behaves exactly like a threshold of one.
  function automatic logic [31:0] eff_threshold(input logic [31:0] thr);
    return (thr == 32'd0) ? 32'd1 : thr;
  endfunction

endpackage

// File: rtl/csr_enc_sat_counter.sv
// Loadable up-counter that sticks at all-ones instead of wrapping.
// Load has priority over increment; synchronous active-high reset clears it.
module csr_enc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/csr_enc_hls_deadlock_report.sv
// Debounces the deadlock monitor's block indication into a sticky event,
// capturing a snapshot, a one-cycle irq and saturating stall/event statistics.
module csr_enc_hls_deadlock_report
  import csr_enc_deadlock_pkg::*;
#(
  parameter int NUM_AXIS = 4,
  parameter int NUM_INST = 4,
  parameter int THRESH_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [THRESH_W-1:0] threshold,
  input  logic                clear,
  output logic                deadlock,
  output logic                deadlock_irq,
  output logic [NUM_AXIS-1:0] snap_axis,
  output logic [NUM_INST-1:0] snap_idle,
  output logic [STALL_W-1:0]  stall_cycles,
  output logic [EVT_W-1:0]    event_count
);

  state_t              state_q, state_d;
  logic                deadlock_q, deadlock_d;
  logic                irq_q, irq_d;
  logic [NUM_AXIS-1:0] snap_axis_q, snap_axis_d;
  logic [NUM_INST-1:0] snap_idle_q, snap_idle_d;

  logic [THRESH_W-1:0] run;
  logic [THRESH_W-1:0] run_load_val;
  logic                run_load, run_inc;
  logic                stall_load, stall_inc;
  logic                evt_inc;
  logic                enter;
  logic [31:0]         eff_thr;
  logic [31:0]         run_plus1;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    eff_thr      = eff_threshold(32'(threshold));
    run_plus1    = 32'(run) + 32'd1;
    state_d      = state_q;
    deadlock_d   = deadlock_q;
    irq_d        = 1'b0;
    snap_axis_d  = snap_axis_q;
    snap_idle_d  = snap_idle_q;
    run_load     = 1'b0;
    run_inc      = 1'b0;
    run_load_val = '0;
    stall_load   = 1'b0;
    stall_inc    = 1'b0;
    evt_inc      = 1'b0;
    enter        = 1'b0;

    // Clear dominates any qualifying block cycle seen in the same cycle.
    if (clear) begin
      state_d    = IDLE;
      deadlock_d = 1'b0;
      run_load   = 1'b1;
      stall_load = (state_q == DEADLOCK);
    end else begin
      case (state_q)
        IDLE: begin
          if (block_in) begin
            run_load     = 1'b1;
            run_load_val = THRESH_W'(1);
            if (eff_thr == 32'd1) begin
              enter = 1'b1;
            end else begin
              state_d = SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (block_in) begin
            run_inc = 1'b1;
            enter   = (run_plus1 >= eff_thr);
          end else begin
            state_d  = IDLE;
            run_load = 1'b1;
          end
        end
        DEADLOCK: begin
          stall_inc = block_in;
        end
        default: begin
          state_d  = IDLE;
          run_load = 1'b1;
        end
      endcase
    end

    if (enter) begin
      state_d     = DEADLOCK;
      deadlock_d  = 1'b1;
      irq_d       = 1'b1;
      snap_axis_d = axis_block_sigs;
      snap_idle_d = inst_idle_sigs;
      stall_load  = 1'b1;
      evt_inc     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      deadlock_q  <= 1'b0;
      irq_q       <= 1'b0;
      snap_axis_q <= '0;
      snap_idle_q <= '0;
    end else begin
      state_q     <= state_d;
      deadlock_q  <= deadlock_d;
      irq_q       <= irq_d;
      snap_axis_q <= snap_axis_d;
      snap_idle_q <= snap_idle_d;
    end
  end

  csr_enc_sat_counter #(.W(THRESH_W)) u_run_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (run_load),
    .inc      (run_inc),
    .load_val (run_load_val),
    .q        (run)
  );

  csr_enc_sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (stall_load),
    .inc      (stall_inc),
    .load_val ('0),
    .q        (stall_cycles)
  );

  csr_enc_sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (1'b0),
    .inc      (evt_inc),
    .load_val ('0),
    .q        (event_count)
  );

  assign deadlock     = deadlock_q;
  assign deadlock_irq = irq_q;
  assign snap_axis    = snap_axis_q;
  assign snap_idle    = snap_idle_q;

endmodule
